fifo_uart_tx: RTL and testbench

- Downstream consumer of the team's synchronous FIFO.
- Pops one WIDTH-bit word at a time through the FIFO read port (rd_en/empty/data_out) and serialises it onto a single UART-style line.
- Frame format: start bit, LSB-first data bits, optional parity bit, stop bit.
- Sits between the FIFO and the chip pad / debug TX line.

---
 rtl/fifo_uart_tx_pkg.sv | 22 ++
 rtl/fifo_uart_tx_if.sv | 32 +++
 rtl/fifo_uart_baud_cnt.sv | 28 ++
 rtl/fifo_uart_tx.sv | 128 ++++++++++++
 tb/tb_fifo_uart_tx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// The parity stage is built only when FIFO_UART_TX_PARITY_EN is defined.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic TX_IDLE_LVL = 1'b1;

  // Serial bits per frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned width, input bit parity_en);
    return width + 32'd2 + (parity_en ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read port plus serial line and status for fifo_uart_tx.
// The master side is the FIFO/system; the slave side is the transmitter.
interface fifo_uart_tx_if #(
  parameter int unsigned WIDTH = 8
);

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd_en;
  logic             tx;
  logic             busy;
  logic             frame_done;

  modport master (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  tx,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output tx,
    output busy,
    output frame_done
  );

endinterface

// File: rtl/fifo_uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module fifo_uart_baud_cnt #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr || (r_cnt == CNT_MAX)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bit_tick = (r_cnt == CNT_MAX);

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops words from a synchronous FIFO and serialises them LSB-first as UART frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_shift;
  logic [IDX_W-1:0]  r_bit_idx;
  logic              w_bit_tick;
  logic              w_baud_clr;
  logic              w_tx;
  logic              w_busy;
  logic              w_rd_en;
  logic              w_frame_done;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              r_parity;
`endif

  fifo_uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (w_baud_clr),
    .bit_tick (w_bit_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and Moore-decoded outputs; the empty flag is only looked at in IDLE.
  always_comb begin
    w_state_nxt  = r_state;
    w_tx         = TX_IDLE_LVL;
    w_busy       = 1'b1;
    w_rd_en      = 1'b0;
    w_frame_done = 1'b0;
    w_baud_clr   = 1'b0;
    case (r_state)
      IDLE: begin
        w_busy     = 1'b0;
        w_baud_clr = 1'b1;
        if (!bus.fifo_empty) w_state_nxt = FETCH;
      end
      FETCH: begin
        w_rd_en     = 1'b1;
        w_baud_clr  = 1'b1;
        w_state_nxt = LOAD;
      end
      LOAD: begin
        w_baud_clr  = 1'b1;
        w_state_nxt = START;
      end
      START: begin
        w_tx = 1'b0;
        if (w_bit_tick) w_state_nxt = DATA;
      end
      DATA: begin
        w_tx = r_shift[0];
        if (w_bit_tick && (r_bit_idx == LAST_IDX)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          w_state_nxt = PARITY;
`else
          w_state_nxt = STOP;
`endif
        end
      end
      PARITY: begin
`ifdef FIFO_UART_TX_PARITY_EN
        w_tx = r_parity;
        if (w_bit_tick) w_state_nxt = STOP;
`else
        w_state_nxt = IDLE;
`endif
      end
      STOP: begin
        w_frame_done = w_bit_tick;
        if (w_bit_tick) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Word capture in LOAD, right shift at the end of each data bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else if (r_state == LOAD) begin
      r_shift   <= bus.fifo_data;
      r_bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      r_parity  <= ^bus.fifo_data;
`endif
    end else if ((r_state == DATA) && w_bit_tick) begin
      r_shift   <= r_shift >> 1;
      r_bit_idx <= r_bit_idx + IDX_W'(1);
    end
  end

  assign bus.tx         = w_tx;
  assign bus.busy       = w_busy;
  assign bus.fifo_rd_en = w_rd_en;
  assign bus.frame_done = w_frame_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: a FIFO model feeds words, a monitor decodes the serial line.
// Build with FIFO_UART_TX_PARITY_EN defined to cover the parity frame.
module tb_fifo_uart_tx;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CPB   = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int unsigned PAR = 1;
`else
  localparam int unsigned PAR = 0;
`endif
  localparam int unsigned FB        = WIDTH + 2 + PAR;
  localparam int unsigned FRAME_CYC = FB * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_uart_tx_if #(.WIDTH(WIDTH)) bus ();

  fifo_uart_tx #(
    .WIDTH        (WIDTH),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic             m_empty = 1'b1;
  logic [WIDTH-1:0] m_data  = '0;
  logic             force_empty = 1'b0;
  logic             load_pend = 1'b0;
  logic [WIDTH-1:0] pend_word = '0;
  int               rd_total = 0;

  assign bus.fifo_empty = m_empty;
  assign bus.fifo_data  = m_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // FIFO model: registered read data appears the cycle after the pop request.
  always @(negedge clk) begin
    if (load_pend) begin
      m_data    = pend_word;
      load_pend = 1'b0;
    end
    if (bus.fifo_rd_en && !rst) begin
      rd_total++;
      chk("rd_en_while_empty", 32'(fifo_q.size() == 0), 32'd0);
      if (fifo_q.size() != 0) begin
        pend_word = fifo_q.pop_front();
        load_pend = 1'b1;
      end
    end
    m_empty = (fifo_q.size() == 0) || force_empty;
  end

  // Monitor: decodes each frame from tx and compares against the scoreboard.
  int               cyc = 0;
  int               fetch_cyc = 0;
  int               m_pos = 0;
  int               gap = 0;
  int               rd_since = 0;
  bit               m_active = 1'b0;
  bit               gap_chk = 1'b0;
  bit               post_frame = 1'b0;
  bit               prev_rd = 1'b0;
  logic [WIDTH-1:0] m_word = '0;

  always @(negedge clk) begin
    int   b;
    logic lvl;
    cyc++;
    if (rst) begin
      m_active   = 1'b0;
      gap_chk    = 1'b0;
      post_frame = 1'b0;
      rd_since   = 0;
      prev_rd    = 1'b0;
      gap        = 0;
    end else begin
      if (bus.fifo_rd_en) begin
        rd_since++;
        fetch_cyc = cyc;
        chk("rd_en_pulse_width", 32'(prev_rd), 32'd0);
      end
      prev_rd = bus.fifo_rd_en;
      if (!m_active) begin
        if (bus.tx == 1'b0) begin
          chk("rd_en_per_frame", 32'(rd_since), 32'd1);
          rd_since = 0;
          if (gap_chk) chk("interframe_gap", 32'(gap), 32'd3);
          chk("start_latency", 32'(cyc - fetch_cyc), 32'd2);
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
            m_word = '0;
          end else begin
            m_word = exp_q.pop_front();
          end
          m_active   = 1'b1;
          m_pos      = 0;
          gap_chk    = 1'b0;
          post_frame = 1'b0;
        end else begin
          gap++;
          if (post_frame && gap == 1) chk("busy_after_stop", 32'(bus.busy), 32'd0);
          chk("frame_done_idle", 32'(bus.frame_done), 32'd0);
        end
      end
      if (m_active) begin
        b = m_pos / CPB;
        if (b == 0) lvl = 1'b0;
        else if (b <= WIDTH) lvl = m_word[b-1];
        else if (PAR == 1 && b == WIDTH + 1) lvl = ^m_word;
        else lvl = 1'b1;
        chk("tx_level", 32'(bus.tx), 32'(lvl));
        chk("busy_in_frame", 32'(bus.busy), 32'd1);
        chk("frame_done", 32'(bus.frame_done), 32'(m_pos == FRAME_CYC - 1));
        if (m_pos == FRAME_CYC - 1) begin
          chk("done_latency", 32'(cyc - fetch_cyc), 32'(FRAME_CYC + 1));
          m_active   = 1'b0;
          gap        = 0;
          post_frame = 1'b1;
          gap_chk    = (fifo_q.size() != 0) && !force_empty;
        end
        m_pos++;
      end
    end
  end

  task automatic wait_rd();
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.fifo_rd_en) seen = 1'b1;
    end
    if (!seen) chk("wait_rd_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_quiet();
    int quiet = 0;
    for (int i = 0; i < 3000 && quiet < 5; i++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && exp_q.size() == 0 && !load_pend && !m_active && !bus.busy)
        quiet++;
      else
        quiet = 0;
    end
    if (quiet < 5) chk("wait_quiet_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(bus.tx), 32'd1);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    chk("reset_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    chk("reset_frame_done", 32'(bus.frame_done), 32'd0);
    rst = 1'b0;

    // Empty FIFO: the line must stay idle and nothing is popped.
    repeat (100) @(negedge clk);
    chk("idle_rd_count", 32'(rd_total), 32'd0);
    chk("idle_tx", 32'(bus.tx), 32'd1);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    push(8'hA5);
    wait_quiet();
    chk("single_rd_count", 32'(rd_total), 32'd1);

    // Preloaded burst: frames run back to back with a 3-cycle gap.
    push(8'h00);
    push(8'hFF);
    push(8'h01);
    push(8'h80);
    wait_quiet();
    chk("burst_rd_count", 32'(rd_total), 32'd5);

    // Empty flag wiggles during DATA must not cause extra pops.
    push(8'h3C);
    wait_rd();
    push(8'h96);
    repeat (12) @(negedge clk);
    force_empty = 1'b1;
    repeat (4) @(negedge clk);
    force_empty = 1'b0;
    repeat (3) @(negedge clk);
    force_empty = 1'b1;
    repeat (3) @(negedge clk);
    force_empty = 1'b0;
    wait_quiet();
    chk("toggle_rd_count", 32'(rd_total), 32'd7);

    // Async reset 20 cycles after FETCH; bit 3 of 8'hC3 (a 0) is on the line.
    push(8'hC3);
    push(8'h5A);
    wait_rd();
    repeat (20) @(posedge clk);
    #2;
    chk("pre_reset_tx", 32'(bus.tx), 32'd0);
    rst = 1'b1;
    #1;
    chk("async_reset_tx", 32'(bus.tx), 32'd1);
    chk("async_reset_busy", 32'(bus.busy), 32'd0);
    chk("async_reset_rd_en", 32'(bus.fifo_rd_en), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_quiet();
    chk("reset_rd_count", 32'(rd_total), 32'd9);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
